// File: rtl/uart_pkg.sv
// UART shared package: clock/baud defaults, bit-timing derivation
// and the receiver state encoding (also used by the transmitter).
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 65_000_000;
  localparam int unsigned BAUD_RATE_DEF = 9_600;
  localparam int unsigned CNT_W         = 14;

  function automatic int unsigned bit_cycles(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

  localparam int unsigned BIT_CYCLES =
    bit_cycles(CLK_FREQ_DEF, BAUD_RATE_DEF);
  localparam int unsigned HALF_BIT = BIT_CYCLES / 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-low reset to 1 (idle line).
// Ports: clk_i, rst_ni, d_i (async in), q_o (synchronized out).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_score_rx.sv
// 8N1 UART receiver latching a two-player score byte.
// Ports: clk, rst (async active-low), RxD (serial in),
//   points_first_player = byte[3:0], points_second_player = byte[7:4],
//   data_valid / frame_error (one-cycle pulses).
// Option: define RX_MAJORITY_VOTE_EN for 2-of-3 voting at each
//   sample point; the decision then lands one cycle after target.
module uart_score_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [3:0] points_first_player,
  output logic [3:0] points_second_player,
  output logic       data_valid,
  output logic       frame_error
);

  localparam int unsigned BITC  = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALFC = BITC / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALFC - 1);

  logic             rxd_sync;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [3:0]       p1_q;
  logic [3:0]       p2_q;
  logic             dv_q;
  logic             fe_q;

  logic             run;
  logic             hit;
  logic             smp_ev;
  logic             smp;
  logic [CNT_W-1:0] tgt;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (RxD),
    .q_o    (rxd_sync)
  );

  assign run = (state_q == RX_START) ||
               (state_q == RX_DATA)  ||
               (state_q == RX_STOP);
  assign tgt = (state_q == RX_START) ? HALF_LAST : BIT_LAST;
  assign hit = run && (cnt_q == tgt);

`ifdef RX_MAJORITY_VOTE_EN
  // Counter clears on target as usual; the vote is resolved one
  // cycle later once the target+1 sample is on rxd_sync.
  logic pend_q;
  logic h1_q;
  logic h2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      h1_q   <= 1'b1;
      h2_q   <= 1'b1;
    end else begin
      pend_q <= hit;
      h1_q   <= rxd_sync;
      h2_q   <= h1_q;
    end
  end

  assign smp_ev = pend_q;
  assign smp    = (h2_q & h1_q) |
                  (h2_q & rxd_sync) |
                  (h1_q & rxd_sync);
`else
  assign smp_ev = hit;
  assign smp    = rxd_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      if (run) begin
        cnt_q <= hit ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        RX_IDLE: begin
          if (!rxd_sync) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (smp_ev) begin
            idx_q   <= '0;
            state_q <= smp ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (smp_ev) begin
            shift_q <= {smp, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
              state_q <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (smp_ev) begin
            if (smp) begin
              p1_q    <= shift_q[3:0];
              p2_q    <= shift_q[7:4];
              dv_q    <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              fe_q    <= 1'b1;
              state_q <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_sync) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign points_first_player  = p1_q;
  assign points_second_player = p2_q;
  assign data_valid           = dv_q;
  assign frame_error          = fe_q;

endmodule

// File: tb/tb_uart_score_rx.sv
// Self-checking bench for uart_score_rx with a score scoreboard.
// Runs at a reduced bit time (20 clocks/bit) to keep frames short.
module tb_uart_score_rx;

  localparam int unsigned CF = 1_920_000;
  localparam int unsigned BR = 96_000;
  localparam int B = CF / BR;
  localparam int H = B / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RxD = 1'b1;
  logic [3:0] p1;
  logic [3:0] p2;
  logic       dv;
  logic       fe;

  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  longint     t_start = 0;
  longint     t_dv = -1;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         fe_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  uart_score_rx #(
    .CLK_FREQ  (CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .RxD                  (RxD),
    .points_first_player  (p1),
    .points_second_player (p2),
    .data_valid           (dv),
    .frame_error          (fe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboard / pulse monitor
  always @(negedge clk) begin
    if (dv || fe) begin
      checks++;
      if (dv && fe) begin
        failures++;
        $display("FAIL dv_fe_overlap dv=%b fe=%b want not both", dv, fe);
      end
    end
    if (dv) begin
      dv_cnt++;
      t_dv = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dv got=%h%h want no pulse", p2, p1);
      end else begin
        e = exp_q.pop_front();
        if ({p2, p1} !== e) begin
          failures++;
          $display("FAIL score got=%h%h want=%h", p2, p1, e);
        end
      end
    end
    if (fe) begin
      fe_cnt++;
      checks++;
      if (fe_exp == 0) begin
        failures++;
        $display("FAIL unexpected_fe got=1 want=0");
      end else begin
        fe_exp--;
      end
    end
  end

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit spike);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < B; j++) begin
        RxD = (spike && j == H) ? ~fr[i] : fr[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] w1,
                         input logic [3:0] w2);
    checks++;
    if (p1 !== w1 || p2 !== w2) begin
      failures++;
      $display("FAIL %s got first=%h second=%h want first=%h second=%h",
               nm, p1, p2, w1, w2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({p1, p2, dv, fe} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=0", {p1, p2, dv, fe});
    end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    longint lat;
    exp_q.push_back(8'h3A);
    t_dv = -1;
    send_frame(8'h3A, 1'b1, 1'b0);
    idle(B);
    chk_out("basic_3A", 4'hA, 4'h3);
    lat = t_dv - t_start;
    checks++;
    if (t_dv < 0 || lat < B * 19 / 2 || lat > B * 19 / 2 + 4) begin
      failures++;
      $display("FAIL latency got=%0d want=%0d+-2", lat, B * 19 / 2 + 2);
    end
  endtask

  task automatic test_frame_error();
    int d0;
    int f0;
    d0 = dv_cnt;
    f0 = fe_cnt;
    fe_exp = 1;
    send_frame(8'h55, 1'b0, 1'b0);
    RxD = 1'b0;
    repeat (12 * B) @(negedge clk);
    checks++;
    if (fe_cnt - f0 !== 1 || dv_cnt !== d0) begin
      failures++;
      $display("FAIL frame_err got fe=%0d dv=%0d want fe=1 dv=0",
               fe_cnt - f0, dv_cnt - d0);
    end
    chk_out("fe_hold", 4'hA, 4'h3);
    idle(2 * B);
  endtask

  task automatic test_glitch();
    int d0;
    int f0;
    d0 = dv_cnt;
    f0 = fe_cnt;
    RxD = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(3 * B);
    checks++;
    if (dv_cnt !== d0 || fe_cnt !== f0) begin
      failures++;
      $display("FAIL glitch got dv=%0d fe=%0d want 0 0",
               dv_cnt - d0, fe_cnt - f0);
    end
    chk_out("glitch_hold", 4'hA, 4'h3);
    exp_q.push_back(8'h5C);
    send_frame(8'h5C, 1'b1, 1'b0);
    idle(B);
    chk_out("after_glitch", 4'hC, 4'h5);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = dv_cnt;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    idle(B);
    checks++;
    if (dv_cnt - d0 !== 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=2", dv_cnt - d0);
    end
    chk_out("b2b_final", 4'h4, 4'h3);
  endtask

  task automatic test_reset_mid();
    logic [8:0] fr;
    fr = {8'hE7, 1'b0};
    for (int i = 0; i < 5; i++) begin
      RxD = fr[i];
      repeat (B) @(negedge clk);
    end
    RxD = fr[5];
    repeat (H) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({p1, p2, dv, fe} !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b want=0", {p1, p2, dv, fe});
    end
    RxD = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2 * B);
    chk_out("post_reset_idle", 4'h0, 4'h0);
    exp_q.push_back(8'h21);
    send_frame(8'h21, 1'b1, 1'b0);
    idle(B);
    chk_out("post_reset_21", 4'h1, 4'h2);
  endtask

`ifdef RX_MAJORITY_VOTE_EN
  task automatic test_vote();
    int f0;
    f0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(B);
    chk_out("vote_A5", 4'h5, 4'hA);
    checks++;
    if (fe_cnt !== f0) begin
      failures++;
      $display("FAIL vote_fe got=%0d want=0", fe_cnt - f0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
`ifdef RX_MAJORITY_VOTE_EN
    test_vote();
`endif
    checks++;
    if (exp_q.size() !== 0 || fe_exp !== 0) begin
      failures++;
      $display("FAIL pending got exp=%0d fe=%0d want 0 0",
               exp_q.size(), fe_exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
